// File: rtl/qsn_deshift_ctrl_len15_if.sv
// rtl/qsn_deshift_ctrl_len15_if.sv - handshake and select bus for the QSN de-shift controller
// master drives forward/return requests; slave is the controller returning selects and status.
interface qsn_deshift_ctrl_len15_if;
  logic        fwd_valid;
  logic [3:0]  fwd_shift;
  logic        fwd_ready;
  logic        ret_valid;
  logic        ret_ready;
  logic [3:0]  left_sel;
  logic [3:0]  right_sel;
  logic [13:0] merge_sel;
  logic        sel_valid;
  logic [3:0]  occupancy;
  logic        err_clr;
  logic [2:0]  err_flags;

  modport master (
    output fwd_valid, fwd_shift, ret_valid, err_clr,
    input  fwd_ready, ret_ready, left_sel, right_sel, merge_sel,
           sel_valid, occupancy, err_flags
  );

  modport slave (
    input  fwd_valid, fwd_shift, ret_valid, err_clr,
    output fwd_ready, ret_ready, left_sel, right_sel, merge_sel,
           sel_valid, occupancy, err_flags
  );
endinterface

// File: rtl/qsn_deshift_ctrl_len15.sv
// rtl/qsn_deshift_ctrl_len15.sv - forward-shift factor store and inverse-shift select generator
// Optional sticky error flags are built only when QSN_DESHIFT_ERR_EN is defined.
module qsn_deshift_ctrl_len15 #(
  parameter int PERMUTATION_LENGTH = 15,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  qsn_deshift_ctrl_len15_if.slave  bus
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
  localparam logic [3:0] PL_L    = 4'(PERMUTATION_LENGTH);

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic [3:0]    r_left_sel;
  logic [3:0]    r_right_sel;
  logic [13:0]   r_merge_sel;
  logic          r_sel_valid;

  logic          w_fwd_ready;
  logic          w_ret_ready;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_s;
  logic          w_s_illegal;
  logic [3:0]    w_s_eff;
  logic [3:0]    w_left;
  logic [13:0]   w_merge;

  // Ready flags look only at registered occupancy, never at the valids.
  assign w_fwd_ready = (r_count < DEPTH_L);
  assign w_ret_ready = (r_count != 4'd0);
  assign w_push      = bus.fwd_valid & w_fwd_ready;
  assign w_pop       = bus.ret_valid & w_ret_ready;

  assign w_s         = r_mem[r_rd_ptr];
  assign w_s_illegal = (w_s >= PL_L);
  assign w_s_eff     = w_s_illegal ? 4'd0 : w_s;

  // right_sel equals s itself; merge keeps the low s bits, which is 0 when r = 0.
  always_comb begin
    w_left  = '0;
    w_merge = '0;
    if (w_s_eff != 4'd0) begin
      w_left = PL_L - w_s_eff;
    end
    for (int i = 0; i < 14; i++) begin
      w_merge[i] = (4'(i) < w_s_eff);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.fwd_shift;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_left_sel  <= '0;
      r_right_sel <= '0;
      r_merge_sel <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_sel_valid <= w_pop;
      if (w_pop) begin
        r_left_sel  <= w_left;
        r_right_sel <= w_s_eff;
        r_merge_sel <= w_merge;
      end
    end
  end

`ifdef QSN_DESHIFT_ERR_EN
  logic [2:0] r_err_flags;
  logic [2:0] w_err_set;

  assign w_err_set = {w_pop & w_s_illegal,
                      bus.ret_valid & ~w_ret_ready,
                      bus.fwd_valid & ~w_fwd_ready};

  // A coincident set event wins over the clear.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_err_flags <= '0;
    end else if (bus.err_clr) begin
      r_err_flags <= w_err_set;
    end else begin
      r_err_flags <= r_err_flags | w_err_set;
    end
  end

  assign bus.err_flags = r_err_flags;
`else
  assign bus.err_flags = 3'b000;
`endif

  assign bus.fwd_ready = w_fwd_ready;
  assign bus.ret_ready = w_ret_ready;
  assign bus.left_sel  = r_left_sel;
  assign bus.right_sel = r_right_sel;
  assign bus.merge_sel = r_merge_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.occupancy = r_count;

endmodule

// File: tb/tb_qsn_deshift_ctrl_len15.sv
// tb/tb_qsn_deshift_ctrl_len15.sv - directed self-checking bench for qsn_deshift_ctrl_len15
module tb_qsn_deshift_ctrl_len15;

`ifdef QSN_DESHIFT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   q_model[$];
  int   s_exp;

  qsn_deshift_ctrl_len15_if bus ();

  qsn_deshift_ctrl_len15 #(
    .PERMUTATION_LENGTH (15),
    .FIFO_DEPTH         (8)
  ) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] s);
    bus.fwd_valid = 1'b1;
    bus.fwd_shift = s;
    tick();
    bus.fwd_valid = 1'b0;
  endtask

  task automatic pop();
    bus.ret_valid = 1'b1;
    tick();
    bus.ret_valid = 1'b0;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_after_clr", 32'(bus.err_flags), 32'd0);
  endtask

  initial begin
    bus.fwd_valid = 1'b0;
    bus.fwd_shift = 4'd0;
    bus.ret_valid = 1'b0;
    bus.err_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_occ",       32'(bus.occupancy), 32'd0);
    check("rst_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("rst_ret_ready", 32'(bus.ret_ready), 32'd0);
    check("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("rst_left",      32'(bus.left_sel),  32'd0);
    check("rst_right",     32'(bus.right_sel), 32'd0);
    check("rst_merge",     32'(bus.merge_sel), 32'd0);
    check("rst_err",       32'(bus.err_flags), 32'd0);
    rstn = 1'b1;
    tick();

    // Push s=3 then pop
    push(4'd3);
    check("p3_occ",       32'(bus.occupancy), 32'd1);
    check("p3_ret_ready", 32'(bus.ret_ready), 32'd1);
    check("p3_sv_before", 32'(bus.sel_valid), 32'd0);
    pop();
    check("p3_sel_valid", 32'(bus.sel_valid), 32'd1);
    check("p3_left",      32'(bus.left_sel),  32'd12);
    check("p3_right",     32'(bus.right_sel), 32'd3);
    check("p3_merge",     32'(bus.merge_sel), 32'h0007);
    check("p3_occ_after", 32'(bus.occupancy), 32'd0);
    tick();
    check("p3_sv_pulse",  32'(bus.sel_valid), 32'd0);
    check("p3_left_hold", 32'(bus.left_sel),  32'd12);
    check("p3_merge_hold",32'(bus.merge_sel), 32'h0007);

    // Push s=0 then pop
    push(4'd0);
    pop();
    check("p0_sel_valid", 32'(bus.sel_valid), 32'd1);
    check("p0_left",      32'(bus.left_sel),  32'd0);
    check("p0_right",     32'(bus.right_sel), 32'd0);
    check("p0_merge",     32'(bus.merge_sel), 32'd0);

    // Fill with 1..8, overflow attempt, then drain
    for (int k = 1; k <= 8; k++) begin
      push(4'(k));
    end
    check("full_occ",       32'(bus.occupancy), 32'd8);
    check("full_fwd_ready", 32'(bus.fwd_ready), 32'd0);
    push(4'd9);
    check("ovf_occ", 32'(bus.occupancy), 32'd8);
    check("ovf_err", 32'(bus.err_flags), ERR_EN ? 32'd1 : 32'd0);
    bus.ret_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("drain_sv",    32'(bus.sel_valid), 32'd1);
      check("drain_left",  32'(bus.left_sel),  32'(15 - k));
      check("drain_right", 32'(bus.right_sel), 32'(k));
    end
    bus.ret_valid = 1'b0;
    check("drain_occ", 32'(bus.occupancy), 32'd0);
    tick();
    check("drain_sv_end", 32'(bus.sel_valid), 32'd0);
    clear_err();

    // Steady state push+pop at occupancy 4, across pointer wrap
    for (int k = 10; k <= 13; k++) begin
      push(4'(k));
      q_model.push_back(k);
    end
    check("ss_occ_start", 32'(bus.occupancy), 32'd4);
    bus.fwd_valid = 1'b1;
    bus.ret_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.fwd_shift = 4'(k);
      q_model.push_back(k);
      tick();
      s_exp = q_model.pop_front();
      check("ss_sv",    32'(bus.sel_valid), 32'd1);
      check("ss_left",  32'(bus.left_sel),  32'(15 - s_exp));
      check("ss_merge", 32'(bus.merge_sel), 32'((1 << s_exp) - 1));
      check("ss_occ",   32'(bus.occupancy), 32'd4);
    end
    bus.fwd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      s_exp = q_model.pop_front();
      check("ss_tail_left",  32'(bus.left_sel),  32'(15 - s_exp));
      check("ss_tail_right", 32'(bus.right_sel), 32'(s_exp));
    end
    bus.ret_valid = 1'b0;
    check("ss_occ_end", 32'(bus.occupancy), 32'd0);

    // Pop from empty store
    pop();
    check("empty_sv",    32'(bus.sel_valid), 32'd0);
    check("empty_left",  32'(bus.left_sel),  32'd5);
    check("empty_right", 32'(bus.right_sel), 32'd10);
    check("empty_merge", 32'(bus.merge_sel), 32'h03FF);
    check("empty_err",   32'(bus.err_flags), ERR_EN ? 32'd2 : 32'd0);
    clear_err();

    // Illegal shift 15
    push(4'd15);
    pop();
    check("ill_sv",    32'(bus.sel_valid), 32'd1);
    check("ill_left",  32'(bus.left_sel),  32'd0);
    check("ill_right", 32'(bus.right_sel), 32'd0);
    check("ill_merge", 32'(bus.merge_sel), 32'd0);
    check("ill_err",   32'(bus.err_flags), ERR_EN ? 32'd4 : 32'd0);

    // Reset with three stored entries
    push(4'd7);
    push(4'd8);
    push(4'd9);
    check("mid_occ", 32'(bus.occupancy), 32'd3);
    rstn = 1'b0;
    #2;
    check("async_occ",   32'(bus.occupancy), 32'd0);
    check("async_left",  32'(bus.left_sel),  32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("rel_occ",       32'(bus.occupancy), 32'd0);
    check("rel_ret_ready", 32'(bus.ret_ready), 32'd0);
    check("rel_err",       32'(bus.err_flags), 32'd0);
    push(4'd5);
    pop();
    check("rel_first_left",  32'(bus.left_sel),  32'd10);
    check("rel_first_right", 32'(bus.right_sel), 32'd5);
    check("rel_first_merge", 32'(bus.merge_sel), 32'h001F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qsn_deshift_ctrl_len15.md
QSN_DESHIFT_CTRL_LEN15 -- requirements
Module: qsn_deshift_ctrl_len15

Interface
REQ-001 Parameter: PERMUTATION_LENGTH, default 15, circulant size Z; shift factors are legal in 0..Z-1.
REQ-002 Parameter: FIFO_DEPTH, default 8, number of stored forward shift factors; power of two, minimum 2.
REQ-003 Port: sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rstn  input  1  asynchronous active-low reset.
REQ-005 Port: fwd_valid  input  1  a forward-rotated message was issued with shift fwd_shift.
REQ-006 Port: fwd_shift  input  4  forward shift factor of the issued message.
REQ-007 Port: fwd_ready  output  1  factor store can accept a push (count < FIFO_DEPTH).
REQ-008 Port: ret_valid  input  1  a returning message needs its de-shift selects.
REQ-009 Port: ret_ready  output  1  a stored factor is available (count > 0).
REQ-010 Port: left_sel  output  4  inverse-shift left selector.
REQ-011 Port: right_sel  output  4  inverse-shift right selector.
REQ-012 Port: merge_sel  output  14  inverse-shift merge thermometer.
REQ-013 Port: sel_valid  output  1  selects updated this cycle; one-cycle pulse.
REQ-014 Port: occupancy  output  4  number of stored factors, 0..FIFO_DEPTH.
REQ-015 Port: err_clr  input  1  synchronous clear of error flags.
REQ-016 Port: err_flags  output  3  sticky errors: [0] push when full, [1] pop when empty, [2] illegal shift.

Function
REQ-017 Push: a push occurs when fwd_valid=1 and fwd_ready=1; fwd_shift is written at the write pointer, and the write pointer wraps modulo FIFO_DEPTH.
REQ-018 Pop: a pop occurs when ret_valid=1 and ret_ready=1; the oldest factor s is read in FIFO order, and the read pointer wraps modulo FIFO_DEPTH.
REQ-019 fwd_ready and ret_ready are derived from registered occupancy only; neither depends combinationally on fwd_valid or ret_valid.
REQ-020 Simultaneous push and pop: both execute and occupancy is unchanged.
REQ-021 Push to an empty store is not bypassed; the new factor becomes poppable from the next cycle.
REQ-022 Inverse shift: r = (PERMUTATION_LENGTH - s) mod PERMUTATION_LENGTH, so s=0 gives r=0.
REQ-023 Illegal shift: a stored s >= PERMUTATION_LENGTH is treated as s=0.
REQ-024 Selects for r != 0: left_sel=r, right_sel=PERMUTATION_LENGTH-r (equal to s), merge_sel = (2^(PERMUTATION_LENGTH-r)) - 1, i.e. the low 15-r bits set.
REQ-025 Selects for r = 0: left_sel, right_sel and merge_sel are all 0.
REQ-026 Latency: on the rising edge that completes a pop, left_sel, right_sel and merge_sel are registered and sel_valid=1 for exactly one cycle.
REQ-027 Hold: without a pop, sel_valid=0 and the select outputs hold their previous values.
REQ-028 Back-to-back: one pop per cycle is sustained, with sel_valid high on consecutive cycles.

Reset
REQ-029 When rstn=0, the following clear asynchronously: pointers, occupancy, left_sel, right_sel, merge_sel, sel_valid and err_flags. Storage contents are don't-care.
REQ-030 Reset values: fwd_ready=1 and ret_ready=0.
REQ-031 Reset mid-stream: all stored factors are discarded, and the first push after release is the first pop.

Configuration
REQ-032 Macro: QSN_DESHIFT_ERR_EN.
REQ-033 With QSN_DESHIFT_ERR_EN defined, error flags behave as follows:
- err_flags[0] sets on fwd_valid=1 with fwd_ready=0.
- err_flags[1] sets on ret_valid=1 with ret_ready=0.
- err_flags[2] sets on a pop of s >= PERMUTATION_LENGTH.
- Each flag is sticky until err_clr=1 or reset.
- A set event coinciding with err_clr takes priority (the flag stays 1).
REQ-034 Without QSN_DESHIFT_ERR_EN, err_flags is constant 0, err_clr is ignored, and all other behaviour is identical.

Verification
REQ-035 Reset, then push s=3, then pop: one cycle after the pop, left_sel=12, right_sel=3, merge_sel=14'b00000000000111, sel_valid pulses once.
REQ-036 Push s=0, then pop: left_sel=0, right_sel=0, merge_sel=0, sel_valid=1.
REQ-037 Push 8 factors 1..8 without popping:
- after the 8th push, occupancy=8 and fwd_ready=0;
- a 9th fwd_valid is dropped and sets err_flags[0] (macro defined);
- 8 consecutive pops return left_sel 14,13,...,7 in order.
REQ-038 At occupancy=4, hold fwd_valid and ret_valid high for 10 cycles: occupancy stays 4, with continuous sel_valid and FIFO order preserved across pointer wrap.
REQ-039 ret_valid=1 on an empty store: no sel_valid, outputs hold; err_flags[1]=1 with the macro defined, 0 without it.
REQ-040 Push s=15, then pop: selects are all 0 and err_flags[2]=1 (macro defined). Next, assert rstn=0 with 3 entries stored: after release, occupancy=0, ret_ready=0 and err_flags=0.
